// File: rtl/pulse_recover_if.sv
// Event-line bundle between a pulse_recover receiver and its environment.
//   sig_in     : stretched event level (may be asynchronous to the receiver clock)
//   pulse_out  : one-cycle strobe per accepted event
//   err_short  : one-cycle strobe, active width below the minimum
//   err_long   : one-cycle strobe, active width above the maximum
//   busy       : receiver is qualifying or holding an event
//   last_width : width of the most recent accepted event
interface pulse_recover_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 sig_in;
  logic                 pulse_out;
  logic                 err_short;
  logic                 err_long;
  logic                 busy;
  logic [CNT_WIDTH-1:0] last_width;

  modport master (
    output sig_in,
    input  pulse_out, err_short, err_long, busy, last_width
  );

  modport slave (
    input  sig_in,
    output pulse_out, err_short, err_long, busy, last_width
  );
endinterface

// File: rtl/pulse_recover.sv
// Recovers stretched event levels: synchronizes sig_in, qualifies the active
// width against [MIN_WIDTH, MAX_WIDTH] and emits one single-cycle strobe
// (pulse_out, err_short or err_long) per event.
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : pulse_recover_if slave (sig_in in; strobes, busy, last_width out)
module pulse_recover #(
  parameter string       POLARITY    = "HIGH",
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_WIDTH   = 3,
  parameter int unsigned MAX_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic            clk,
  input  logic            rst,
  pulse_recover_if.slave  bus
);

  localparam logic                 INACTIVE = (POLARITY == "LOW") ? 1'b1 : 1'b0;
  localparam logic [CNT_WIDTH-1:0] MIN_CNT  = CNT_WIDTH'(MIN_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   last_width_q, last_width_d;
  logic                   pulse_q, pulse_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   busy_q, busy_d;
  logic                   act;

  // Last synchronizer stage, normalized so 1 means active.
  assign act = sync_q[SYNC_STAGES-1] ^ INACTIVE;

  // Register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{INACTIVE}};
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_width_q <= '0;
      pulse_q      <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_width_q <= last_width_d;
      pulse_q      <= pulse_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      busy_q       <= busy_d;
    end
  end

  // Synchronizer shift, width qualification FSM and strobe generation.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_width_d = last_width_q;
    pulse_d      = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (act) begin
          cnt_d   = CNT_WIDTH'(1);
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (act) begin
          if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else begin
            // Too long: report once, then park until the line goes inactive.
            err_long_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (cnt_q >= MIN_CNT) begin
          pulse_d      = 1'b1;
          last_width_d = cnt_q;
          state_d      = ST_IDLE;
        end else begin
          err_short_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!act) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_long   = err_long_q;
  assign bus.busy       = busy_q;
  assign bus.last_width = last_width_q;

endmodule

// File: tb/tb_pulse_recover.sv
// Scoreboard bench for pulse_recover: an active-high and an active-low
// instance see the same event stream (the low one inverted); every expected
// strobe (kind, cycle, width) is queued as the stimulus is driven and popped
// when a DUT strobes.
module tb_pulse_recover;

  localparam int unsigned SYNC = 2;
  localparam int unsigned MINW = 3;
  localparam int unsigned MAXW = 64;
  localparam int unsigned CW   = 8;

  typedef struct {
    int kind;   // 0 pulse, 1 short, 2 long
    int cyc;
    int width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_cnt [2];
  exp_t q_hi [$];
  exp_t q_lo [$];

  pulse_recover_if #(.CNT_WIDTH(CW)) if_hi ();
  pulse_recover_if #(.CNT_WIDTH(CW)) if_lo ();

  assign if_hi.sig_in = sig;
  assign if_lo.sig_in = ~sig;

  pulse_recover #(
    .POLARITY("HIGH"), .SYNC_STAGES(SYNC), .MIN_WIDTH(MINW),
    .MAX_WIDTH(MAXW), .CNT_WIDTH(CW)
  ) dut_hi (
    .clk(clk), .rst(rst), .bus(if_hi)
  );

  pulse_recover #(
    .POLARITY("LOW"), .SYNC_STAGES(SYNC), .MIN_WIDTH(MINW),
    .MAX_WIDTH(MAXW), .CNT_WIDTH(CW)
  ) dut_lo (
    .clk(clk), .rst(rst), .bus(if_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every observed strobe.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic          p, es, el, b;
      logic [CW-1:0] lw;
      int            k;
      exp_t          e;
      p  = (d == 0) ? if_hi.pulse_out  : if_lo.pulse_out;
      es = (d == 0) ? if_hi.err_short  : if_lo.err_short;
      el = (d == 0) ? if_hi.err_long   : if_lo.err_long;
      b  = (d == 0) ? if_hi.busy       : if_lo.busy;
      lw = (d == 0) ? if_hi.last_width : if_lo.last_width;
      if (b === 1'b1) busy_cnt[d]++;
      if (p === 1'b1 || es === 1'b1 || el === 1'b1) begin
        n_vec++;
        k = (p === 1'b1) ? 0 : ((es === 1'b1) ? 1 : 2);
        if ((p === 1'b1 ? 1 : 0) + (es === 1'b1 ? 1 : 0) + (el === 1'b1 ? 1 : 0) > 1) begin
          n_bad++;
          $display("FAIL strobe_exclusive dut=%0d cyc=%0d got pulse/short/long=%b%b%b need one-hot", d, cyc, p, es, el);
        end else if ((d == 0 && q_hi.size() == 0) || (d == 1 && q_lo.size() == 0)) begin
          n_bad++;
          $display("FAIL unexpected_strobe dut=%0d cyc=%0d got kind=%0d need none", d, cyc, k);
        end else begin
          e = (d == 0) ? q_hi.pop_front() : q_lo.pop_front();
          if (k != e.kind || cyc != e.cyc || (k == 0 && int'(lw) != e.width)) begin
            n_bad++;
            $display("FAIL strobe_match dut=%0d got kind=%0d cyc=%0d width=%0d need kind=%0d cyc=%0d width=%0d",
                     d, k, cyc, lw, e.kind, e.cyc, e.width);
          end
        end
      end
    end
  end

  // Drive one active level of w cycles and queue the strobe the spec predicts.
  task automatic drive_event(input int w);
    exp_t e;
    @(posedge clk);
    #1;
    if (w < int'(MINW)) begin
      e.kind = 1; e.cyc = cyc + w + int'(SYNC) + 1; e.width = 0;
    end else if (w > int'(MAXW)) begin
      e.kind = 2; e.cyc = cyc + int'(SYNC) + int'(MAXW) + 1; e.width = 0;
    end else begin
      e.kind = 0; e.cyc = cyc + w + int'(SYNC) + 1; e.width = w;
    end
    q_hi.push_back(e);
    q_lo.push_back(e);
    sig = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    sig = 1'b0;
  endtask

  // Bounded wait for both scoreboards to drain and both DUTs to go idle.
  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_hi.size() == 0 && q_lo.size() == 0 && if_hi.busy === 1'b0 && if_lo.busy === 1'b0) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({if_hi.pulse_out, if_hi.err_short, if_hi.err_long, if_hi.busy} !== 4'b0 || if_hi.last_width !== '0) begin
      n_bad++;
      $display("FAIL reset_hi got p/s/l/b=%b%b%b%b lw=%0d need 0000 lw=0",
               if_hi.pulse_out, if_hi.err_short, if_hi.err_long, if_hi.busy, if_hi.last_width);
    end
    n_vec++;
    if ({if_lo.pulse_out, if_lo.err_short, if_lo.err_long, if_lo.busy} !== 4'b0 || if_lo.last_width !== '0) begin
      n_bad++;
      $display("FAIL reset_lo got p/s/l/b=%b%b%b%b lw=%0d need 0000 lw=0",
               if_lo.pulse_out, if_lo.err_short, if_lo.err_long, if_lo.busy, if_lo.last_width);
    end
    n_vec++;
    if (dut_hi.sync_q !== {SYNC{1'b0}} || dut_lo.sync_q !== {SYNC{1'b1}}) begin
      n_bad++;
      $display("FAIL reset_sync got hi=%b lo=%b need hi=all0 lo=all1", dut_hi.sync_q, dut_lo.sync_q);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_lw(input int want, input string tag);
    n_vec++;
    if (int'(if_hi.last_width) != want || int'(if_lo.last_width) != want) begin
      n_bad++;
      $display("FAIL last_width_%s got hi=%0d lo=%0d need %0d", tag, if_hi.last_width, if_lo.last_width, want);
    end
    n_vec++;
    if (q_hi.size() != 0 || q_lo.size() != 0) begin
      n_bad++;
      $display("FAIL drained_%s got pending hi=%0d lo=%0d need 0", tag, q_hi.size(), q_lo.size());
    end
  endtask

  task automatic test_short();
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    drive_event(2);
    wait_idle();
    n_vec++;
    if (busy_cnt[0] != 2 || busy_cnt[1] != 2) begin
      n_bad++;
      $display("FAIL busy_short got hi=%0d lo=%0d need 2", busy_cnt[0], busy_cnt[1]);
    end
    check_lw(0, "short");
  endtask

  task automatic test_basic();
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    drive_event(6);
    wait_idle();
    n_vec++;
    if (busy_cnt[0] != 6 || busy_cnt[1] != 6) begin
      n_bad++;
      $display("FAIL busy_basic got hi=%0d lo=%0d need 6", busy_cnt[0], busy_cnt[1]);
    end
    check_lw(6, "basic");
  endtask

  task automatic test_boundary();
    drive_event(3);
    wait_idle();
    check_lw(3, "min");
    drive_event(64);
    wait_idle();
    check_lw(64, "max");
    drive_event(2);
    wait_idle();
    check_lw(64, "below_min");
    drive_event(65);
    wait_idle();
    check_lw(64, "above_max");
  endtask

  task automatic test_long();
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    drive_event(100);
    wait_idle();
    n_vec++;
    if (busy_cnt[0] != 100 || busy_cnt[1] != 100) begin
      n_bad++;
      $display("FAIL busy_long got hi=%0d lo=%0d need 100", busy_cnt[0], busy_cnt[1]);
    end
    check_lw(64, "long");
  endtask

  task automatic test_back_to_back();
    drive_event(4);
    drive_event(4);
    wait_idle();
    check_lw(4, "b2b");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Reset mid-event with the input gone before release: nothing reported.
    @(posedge clk);
    #1 sig = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 sig = 1'b0;
    rst = 1'b0;
    wait_idle();
    n_vec++;
    if (if_hi.busy !== 1'b0 || if_lo.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_rst_mid got hi=%b lo=%b need 0", if_hi.busy, if_lo.busy);
    end
    check_lw(0, "rst_mid");
    // Input still active after release: counted from the release point.
    @(posedge clk);
    #1 sig = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e.kind = 0; e.cyc = cyc + 8 + int'(SYNC) + 1; e.width = 8;
    q_hi.push_back(e);
    q_lo.push_back(e);
    repeat (8) @(posedge clk);
    #1 sig = 1'b0;
    wait_idle();
    check_lw(8, "rst_resume");
  endtask

  initial begin
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    test_reset();
    test_short();
    test_basic();
    test_boundary();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
